// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3.
// Feeds a multiplexed 7-segment driver with stable digits and blanks.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH     = 10,
  parameter int NUM_DIGITS    = 3,
  parameter int BLANK_LEADING = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [BIN_WIDTH-1:0] bin_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [3:0]           digits_o [NUM_DIGITS],
  output logic                 blank_o  [NUM_DIGITS],
  output logic                 overflow_o,
  output logic                 done_o
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(BIN_WIDTH + 1);

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) p = p * 32'd10;
    return p;
  endfunction

  localparam logic [31:0]   MAX_VAL  = pow10(NUM_DIGITS) - 32'd1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(BIN_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q;
  logic [BW-1:0]        bcd_q;
  logic [BW-1:0]        bcd_adj;
  logic [CW-1:0]        cnt_q;
  logic                 ovf_q;
  logic                 accept;
  logic [31:0]          bin_ext;
  logic [NUM_DIGITS-1:0] blank_d;
  logic                 zero_run;
  logic                 unused_bcd_msb;

  assign ready_o        = (state_q == IDLE);
  assign accept         = valid_i && ready_o;
  assign bin_ext        = 32'(bin_i);
  // Top BCD bit falls off the register on each shift.
  assign unused_bcd_msb = bcd_adj[BW-1];

  // Add 3 to every nibble that is 5 or more before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Leading-zero blanks; units digit always stays visible.
  always_comb begin
    zero_run = 1'b1;
    blank_d  = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run & (bcd_q[4*i +: 4] == 4'h0);
      blank_d[i] = (BLANK_LEADING != 0) && zero_run;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load, shift one bit per cycle, publish results once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      overflow_o <= 1'b0;
      done_o     <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digits_o[i] <= 4'h0;
        blank_o[i]  <= 1'b0;
      end
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            bin_q <= bin_i;
            bcd_q <= '0;
            cnt_q <= CNT_LOAD;
            ovf_q <= (bin_ext > MAX_VAL);
          end
        end
        SHIFT: begin
          bcd_q <= {bcd_adj[BW-2:0], bin_q[BIN_WIDTH-1]};
          bin_q <= {bin_q[BIN_WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q - CW'(1);
        end
        DONE: begin
          done_o     <= 1'b1;
          overflow_o <= ovf_q;
          for (int i = 0; i < NUM_DIGITS; i++) begin
            digits_o[i] <= ovf_q ? 4'hE : bcd_q[4*i +: 4];
            blank_o[i]  <= ovf_q ? 1'b0 : blank_d[i];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: vector table, scoreboard, corner cases.
// Runs a blanking and a non-blanking instance side by side.
module tb_bin_to_bcd_seq;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [9:0] bin;
  logic       valid;
  logic       ready, ready2;
  logic [3:0] dig  [3];
  logic [3:0] dig2 [3];
  logic       blk  [3];
  logic       blk2 [3];
  logic       ovf, ovf2, done, done2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [11:0] dig;
    logic [2:0]  blk;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [9:0] bin;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  exp_t em;
  vec_t tbl[10];

  bin_to_bcd_seq #(.BIN_WIDTH(10), .NUM_DIGITS(3), .BLANK_LEADING(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bin_i(bin), .valid_i(valid),
    .ready_o(ready), .digits_o(dig), .blank_o(blk),
    .overflow_o(ovf), .done_o(done)
  );

  bin_to_bcd_seq #(.BIN_WIDTH(10), .NUM_DIGITS(3), .BLANK_LEADING(0)) dut_nb (
    .clk_i(clk), .rst_ni(rst_n), .bin_i(bin), .valid_i(valid),
    .ready_o(ready2), .digits_o(dig2), .blank_o(blk2),
    .overflow_o(ovf2), .done_o(done2)
  );

  function automatic exp_t model(input int v);
    exp_t r;
    int d2, d1, d0;
    if (v > 999) begin
      r.dig = 12'hEEE;
      r.blk = 3'b000;
      r.ovf = 1'b1;
    end else begin
      d2 = v / 100;
      d1 = (v / 10) % 10;
      d0 = v % 10;
      r.dig = {4'(d2), 4'(d1), 4'(d0)};
      r.blk = {d2 == 0, (d2 == 0) && (d1 == 0), 1'b0};
      r.ovf = 1'b0;
    end
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, a, x, $time);
    end
  endtask

  // Scoreboard: pop an expectation on every done pulse.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        em = sb.pop_front();
        chk("digits", 32'({dig[2], dig[1], dig[0]}), 32'(em.dig));
        chk("blank", 32'({blk[2], blk[1], blk[0]}), 32'(em.blk));
        chk("overflow", 32'(ovf), 32'(em.ovf));
        chk("nb_done", 32'(done2), 32'd1);
        chk("nb_digits", 32'({dig2[2], dig2[1], dig2[0]}), 32'(em.dig));
        chk("nb_blank", 32'({blk2[2], blk2[1], blk2[0]}), 32'd0);
        chk("nb_overflow", 32'(ovf2), 32'(em.ovf));
      end
    end else if (done2) begin
      chk("nb_unexpected_done", 32'(done2), 32'd0);
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic send(input logic [9:0] v, input exp_t e);
    wait_ready();
    bin   = v;
    valid = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    valid = 1'b0;
    bin   = ~v;
  endtask

  initial begin
    tbl[0] = {10'd255,  12'h255, 3'b000, 1'b0};
    tbl[1] = {10'd7,    12'h007, 3'b110, 1'b0};
    tbl[2] = {10'd0,    12'h000, 3'b110, 1'b0};
    tbl[3] = {10'd999,  12'h999, 3'b000, 1'b0};
    tbl[4] = {10'd1000, 12'hEEE, 3'b000, 1'b1};
    tbl[5] = {10'd1023, 12'hEEE, 3'b000, 1'b1};
    tbl[6] = {10'd512,  12'h512, 3'b000, 1'b0};
    tbl[7] = {10'd40,   12'h040, 3'b100, 1'b0};
    tbl[8] = {10'd100,  12'h100, 3'b000, 1'b0};
    tbl[9] = {10'd9,    12'h009, 3'b110, 1'b0};

    rst_n = 1'b0;
    valid = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_digits", 32'({dig[2], dig[1], dig[0]}), 32'd0);
    chk("rst_blank", 32'({blk[2], blk[1], blk[0]}), 32'd0);
    chk("rst_overflow", 32'(ovf), 32'd0);

    // Latency: accept 255 at edge k, done seen after edge k+11.
    bin   = 10'd255;
    valid = 1'b1;
    sb.push_back({12'h255, 3'b000, 1'b0});
    @(posedge clk);
    #1;
    valid = 1'b0;
    bin   = 10'h3FF;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      chk("lat_ready_low", 32'(ready), 32'd0);
      chk("lat_done_early", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("lat_done", 32'(done), 32'd1);
    chk("lat_ready_back", 32'(ready), 32'd1);
    @(negedge clk);
    chk("lat_done_pulse", 32'(done), 32'd0);
    wait_drain();

    // Vector table.
    for (int i = 0; i < 10; i++) begin
      send(tbl[i].bin, tbl[i].e);
      wait_drain();
    end

    // Continuous valid with bin changing every cycle.
    wait_ready();
    for (int c = 0; c < 48; c++) begin
      int v;
      v     = int'($urandom_range(0, 1023));
      bin   = 10'(v);
      valid = 1'b1;
      chk("stream_ready", 32'(ready), 32'(c % 12 == 0));
      if (c % 12 == 0) sb.push_back(model(v));
      @(negedge clk);
    end
    valid = 1'b0;
    wait_drain();

    // Asynchronous reset during SHIFT of 512.
    send(10'd1023, model(1023));
    wait_drain();
    wait_ready();
    bin   = 10'd512;
    valid = 1'b1;
    sb.push_back(model(512));
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_digits", 32'({dig[2], dig[1], dig[0]}), 32'd0);
    chk("arst_blank", 32'({blk[2], blk[1], blk[0]}), 32'd0);
    chk("arst_overflow", 32'(ovf), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_ready", 32'(ready), 32'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      chk("arst_no_done", 32'(done), 32'd0);
    end
    send(10'd512, {12'h512, 3'b000, 1'b0});
    wait_drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
